alu_sequencer: RTL and testbench

Multi-cycle issue and writeback controller that sits directly in front of and behind the 16-bit `alu` datapath. It accepts one register-to-register instruction at a time over a valid/ready handshake. It reads two operands from an internal 8-entry register file, drives them with the opcode onto the `alu` inputs, then captures `alu_output`, `carryout` and `zero_flag` back into the register file and a flag register. It is the block that turns the combinational `alu` into an executable unit.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_if.sv | 86 ++++++++
 rtl/alu_seq_regfile.sv | 56 +++++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared package: FSM state enum,
// NOP opcode and default datapath sizes.
package alu_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OPC_W  = 4;
  localparam int DEF_NREG   = 8;

  localparam logic [3:0] OPC_NOP = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_sequencer bus: instruction handshake, preload,
// alu operand/result path, writeback and status.
// slave  = the sequencer, master = its environment.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int NREG   = DEF_NREG,
  localparam int RW    = $clog2(NREG)
);

  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  instr_opc;
  logic [RW-1:0]     instr_rd;
  logic [RW-1:0]     instr_rs1;
  logic [RW-1:0]     instr_rs2;

  logic              ld_en;
  logic [RW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OPC_W-1:0]  alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  logic              wr_valid;
  logic [RW-1:0]     wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              flag_c;
  logic              flag_z;
  logic              busy;

  modport slave (
    input  instr_valid,
    input  instr_opc,
    input  instr_rd,
    input  instr_rs1,
    input  instr_rs2,
    input  ld_en,
    input  ld_addr,
    input  ld_data,
    input  alu_result,
    input  alu_carry,
    input  alu_zero,
    output instr_ready,
    output alu_a,
    output alu_b,
    output alu_op,
    output wr_valid,
    output wr_rd,
    output wr_data,
    output flag_c,
    output flag_z,
    output busy
  );

  modport master (
    output instr_valid,
    output instr_opc,
    output instr_rd,
    output instr_rs1,
    output instr_rs2,
    output ld_en,
    output ld_addr,
    output ld_data,
    output alu_result,
    output alu_carry,
    output alu_zero,
    input  instr_ready,
    input  alu_a,
    input  alu_b,
    input  alu_op,
    input  wr_valid,
    input  wr_rd,
    input  wr_data,
    input  flag_c,
    input  flag_z,
    input  busy
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// alu_sequencer register file: 2 comb read ports,
// WB write port (wins) + preload write port, sync reset.
// Ports: clk, rst, ra_i/rb_i -> rda_o/rdb_o,
//   wb_en_i/wb_addr_i/wb_data_i, ld_en_i/ld_addr_i/ld_data_i.
// ALU_SEQ_ZERO_R0_EN: r0 is hardwired to zero.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  localparam int RW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     ra_i,
  input  logic [RW-1:0]     rb_i,
  output logic [DATA_W-1:0] rda_o,
  output logic [DATA_W-1:0] rdb_o,
  input  logic              wb_en_i,
  input  logic [RW-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ld_en_i,
  input  logic [RW-1:0]     ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (wb_en_i && wb_addr_i == RW'(i)) begin
        regs_d[i] = wb_data_i;
      end else if (ld_en_i && ld_addr_i == RW'(i)) begin
        regs_d[i] = ld_data_i;
      end
    end
`ifdef ALU_SEQ_ZERO_R0_EN
    // r0 never stores anything, so it always reads 0
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rda_o = regs_q[ra_i];
  assign rdb_o = regs_q[rb_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller around a combinational alu:
// IDLE -> READ -> EXEC -> WB, one instruction per 4 clocks.
// Ports: clk, rst (sync, active high), bus (alu_seq_if.slave).
// ALU_SEQ_ZERO_R0_EN: r0 reads 0 (handled in alu_seq_regfile).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int NREG   = DEF_NREG,
  localparam int RW    = $clog2(NREG)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  state_e state_q, state_d;

  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic [RW-1:0]     rs1_q, rs1_d;
  logic [RW-1:0]     rs2_q, rs2_d;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OPC_W-1:0]  op_q, op_d;

  logic [DATA_W-1:0] res_q, res_d;
  logic              c_q, c_d;
  logic              z_q, z_d;

  logic              fc_q, fc_d;
  logic              fz_q, fz_d;

  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              ready;
  logic              accept;
  logic              is_nop;
  logic              wb_en;

  assign ready  = (state_q == S_IDLE) && !rst;
  assign accept = bus.instr_valid && ready;
  assign is_nop = (opc_q == OPC_W'(OPC_NOP));
  assign wb_en  = (state_q == S_WB) && !is_nop;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .ra_i      (rs1_q),
    .rb_i      (rs2_q),
    .rda_o     (rs1_val),
    .rdb_o     (rs2_val),
    .wb_en_i   (wb_en),
    .wb_addr_i (rd_q),
    .wb_data_i (res_q),
    .ld_en_i   (bus.ld_en),
    .ld_addr_i (bus.ld_addr),
    .ld_data_i (bus.ld_data)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          opc_d   = bus.instr_opc;
          rd_d    = bus.instr_rd;
          rs1_d   = bus.instr_rs1;
          rs2_d   = bus.instr_rs2;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        op_d    = opc_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = bus.alu_result;
        c_d     = bus.alu_carry;
        z_d     = bus.alu_zero;
        state_d = S_WB;
      end
      S_WB: begin
        if (!is_nop) begin
          fc_d = c_q;
          fz_d = z_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.wr_valid    = wb_en;
  assign bus.wr_rd       = rd_q;
  assign bus.wr_data     = res_q;
  assign bus.flag_c      = fc_q;
  assign bus.flag_z      = fz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: alu stub (op1 add, op2 xor),
// timestamp-based reference model, per-cycle compare.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_seq_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [16:0] alu_fn(
    input logic [3:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    case (op)
      4'h1:    return {1'b0, a} + {1'b0, b};
      4'h2:    return {1'b0, a ^ b};
      default: return 17'h0;
    endcase
  endfunction

  logic [16:0] stub;
  assign stub = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_carry  = stub[16];
  assign bus.alu_result = stub[15:0];
  assign bus.alu_zero   = (stub[15:0] == 16'h0);

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted instruction snapshots its
  // operands at the accept edge t and commits at edge t+3.
  logic [15:0] m_reg [8];
  bit          m_busy = 1'b0;
  int          m_t    = 0;
  int          e      = 0;
  logic [3:0]  m_opc  = '0;
  logic [2:0]  m_rd   = '0;
  logic [15:0] m_sa   = '0;
  logic [15:0] m_sb   = '0;
  logic [15:0] m_res  = '0;
  logic        m_c    = 1'b0;
  logic        m_z    = 1'b0;
  logic        m_fc   = 1'b0;
  logic        m_fz   = 1'b0;
  logic [15:0] m_a    = '0;
  logic [15:0] m_b    = '0;
  logic [3:0]  m_op   = '0;
  int          acc_q[$];

  always @(posedge clk) begin
    bit idle_before;
    logic [16:0] r;
    e = e + 1;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_busy = 1'b0;
      m_fc = 1'b0;
      m_fz = 1'b0;
      m_a  = '0;
      m_b  = '0;
      m_op = '0;
    end else begin
      idle_before = !m_busy;
      if (bus.ld_en) m_reg[bus.ld_addr] = bus.ld_data;
      if (m_busy && e == m_t + 3) begin
        if (m_opc != 4'h0) begin
          m_reg[m_rd] = m_res;
          m_fc = m_c;
          m_fz = m_z;
        end
        m_busy = 1'b0;
      end
`ifdef ALU_SEQ_ZERO_R0_EN
      m_reg[0] = '0;
`endif
      if (m_busy && e == m_t + 1) begin
        m_a  = m_sa;
        m_b  = m_sb;
        m_op = m_opc;
      end
      if (idle_before && bus.instr_valid) begin
        m_busy = 1'b1;
        m_t    = e;
        m_opc  = bus.instr_opc;
        m_rd   = bus.instr_rd;
        m_sa   = m_reg[bus.instr_rs1];
        m_sb   = m_reg[bus.instr_rs2];
        r      = alu_fn(m_opc, m_sa, m_sb);
        m_c    = r[16];
        m_res  = r[15:0];
        m_z    = (r[15:0] == 16'h0);
        acc_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_wv;
    #1;
    if (chk_en) begin
      exp_wv = m_busy && (e == m_t + 2) && (m_opc != 4'h0);
      chk("instr_ready", bus.instr_ready, !m_busy && !rst);
      chk("busy", bus.busy, m_busy);
      chk("wr_valid", bus.wr_valid, exp_wv);
      if (exp_wv) begin
        chk("wr_rd", bus.wr_rd, m_rd);
        chk("wr_data", bus.wr_data, m_res);
      end
      chk("flag_c", bus.flag_c, m_fc);
      chk("flag_z", bus.flag_z, m_fz);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_op", bus.alu_op, m_op);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [2:0] a,
                         input logic [15:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(negedge clk);
    bus.ld_en   = 1'b0;
  endtask

  // returns at the negedge just after the accept edge
  task automatic issue(input logic [3:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] s1,
                       input logic [2:0] s2);
    bit ok = 1'b0;
    int k  = 0;
    bus.instr_valid = 1'b1;
    bus.instr_opc   = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = s1;
    bus.instr_rs2   = s2;
    while (!ok && k < 16) begin
      if (bus.instr_ready) ok = 1'b1;
      @(negedge clk);
      k++;
    end
    bus.instr_valid = 1'b0;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!bus.instr_ready && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (k >= 16) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    bus.instr_valid = 1'b0;
    bus.instr_opc   = '0;
    bus.instr_rd    = '0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    foreach (m_reg[i]) m_reg[i] = '0;

    // reset state
    step();
    step();
    chk("rst_ready", bus.instr_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_wr_rd", bus.wr_rd, 3'd0);
    chk("rst_wr_data", bus.wr_data, 16'h0);
    chk("rst_flags", {bus.flag_c, bus.flag_z}, 2'b00);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_alu_op", bus.alu_op, 4'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();

    // 5 + 4 into r3
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0004);
    issue(4'h1, 3'd3, 3'd1, 3'd2);
    step();
    chk("t1_alu_a", bus.alu_a, 16'h0005);
    chk("t1_alu_b", bus.alu_b, 16'h0004);
    step();
    chk("t1_wr_valid", bus.wr_valid, 1'b1);
    chk("t1_wr_rd", bus.wr_rd, 3'd3);
    chk("t1_wr_data", bus.wr_data, 16'h0009);
    step();
    chk("t1_flags", {bus.flag_c, bus.flag_z}, 2'b00);

    // FFFF + 1 into r4: carry and zero
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    issue(4'h1, 3'd4, 3'd1, 3'd2);
    step();
    step();
    chk("t2_wr_data", bus.wr_data, 16'h0000);
    step();
    chk("t2_flags", {bus.flag_c, bus.flag_z}, 2'b11);

    // NOP: no writeback, flags kept, ready after 3 more cycles
    issue(4'h0, 3'd3, 3'd1, 3'd2);
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.instr_ready && k < 10);
    chk("nop_ready_lat", k, 3);
    chk("nop_flags", {bus.flag_c, bus.flag_z}, 2'b11);

    // preload visibility and WB-over-preload priority
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd5;
    bus.ld_data = 16'h0100;
    issue(4'h1, 3'd6, 3'd5, 3'd2);
    bus.ld_data = 16'h0200;
    step();
    bus.ld_en = 1'b0;
    step();
    chk("vis_wr_data", bus.wr_data, 16'h0101);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd6;
    bus.ld_data = 16'hAAAA;
    step();
    bus.ld_en = 1'b0;
    issue(4'h1, 3'd7, 3'd6, 3'd5);
    step();
    step();
    chk("prio_wr_data", bus.wr_data, 16'h0301);
    step();

    // back-to-back: valid held for 12 cycles
    n0 = acc_q.size();
    bus.instr_valid = 1'b1;
    bus.instr_opc   = 4'h1;
    bus.instr_rd    = 3'd2;
    bus.instr_rs1   = 3'd2;
    bus.instr_rs2   = 3'd2;
    repeat (12) step();
    bus.instr_valid = 1'b0;
    chk("stream_count", acc_q.size() - n0, 3);
    if (acc_q.size() - n0 == 3) begin
      chk("stream_gap1", acc_q[n0+1] - acc_q[n0], 4);
      chk("stream_gap2", acc_q[n0+2] - acc_q[n0+1], 4);
    end
    wait_idle();
    issue(4'h1, 3'd1, 3'd2, 3'd2);
    step();
    step();
    chk("stream_wr_data", bus.wr_data, 16'h0010);
    step();

    // reset during EXEC
    issue(4'h1, 3'd3, 3'd1, 3'd2);
    step();
    rst = 1'b1;
    step();
    chk("abort_wr_valid", bus.wr_valid, 1'b0);
    chk("abort_flags", {bus.flag_c, bus.flag_z}, 2'b00);
    rst = 1'b0;
    #1;
    chk("abort_ready", bus.instr_ready, 1'b1);
    step();
    chk("abort_wr_valid2", bus.wr_valid, 1'b0);

    // register 0 behaviour
    preload(3'd0, 16'h1234);
    preload(3'd1, 16'h0007);
    issue(4'h1, 3'd2, 3'd0, 3'd1);
    step();
`ifdef ALU_SEQ_ZERO_R0_EN
    chk("r0_alu_a", bus.alu_a, 16'h0000);
    step();
    chk("r0_wr_data", bus.wr_data, 16'h0007);
`else
    chk("r0_alu_a", bus.alu_a, 16'h1234);
    step();
    chk("r0_wr_data", bus.wr_data, 16'h123B);
`endif
    step();
    issue(4'h1, 3'd0, 3'd1, 3'd1);
    step();
    step();
    chk("r0_wr_valid", bus.wr_valid, 1'b1);
    chk("r0_wr_rd", bus.wr_rd, 3'd0);
    step();
    issue(4'h2, 3'd3, 3'd0, 3'd2);
    step();
`ifdef ALU_SEQ_ZERO_R0_EN
    chk("r0_after_wr", bus.alu_a, 16'h0000);
`else
    chk("r0_after_wr", bus.alu_a, 16'h000E);
`endif
    wait_idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
